serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/sub_pkg.sv | 12 +
 rtl/full_subtractor.sv | 25 ++
 rtl/serial_subtractor.sv | 118 +++++++++++
 tb/tb_serial_subtractor.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor from gate primitives: d = a - b - br_in, with borrow out.
module full_subtractor (
    output logic d,
    output logic br_out,
    input  logic a,
    input  logic b,
    input  logic br_in
);

    logic a_xor_b;
    logic a_n;
    logic xor_n;
    logic borrow_gen;
    logic borrow_prop;

    xor g_x1 (a_xor_b, a, b);
    xor g_x2 (d, a_xor_b, br_in);
    not g_n1 (a_n, a);
    not g_n2 (xor_n, a_xor_b);
    // Borrow is generated when a=0,b=1 and propagated when a==b.
    and g_a1 (borrow_gen, a_n, b);
    and g_a2 (borrow_prop, xor_n, br_in);
    or  g_o1 (br_out, borrow_gen, borrow_prop);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH cycles, LSB first, with a done pulse.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_reg,  state_next;
    logic [WIDTH-1:0] a_sh_reg,   a_sh_next;
    logic [WIDTH-1:0] b_sh_reg,   b_sh_next;
    logic [WIDTH-1:0] diff_reg,   diff_next;
    logic [CW-1:0]    cnt_reg,    cnt_next;
    logic             br_reg,     br_next;
    logic             bout_reg,   bout_next;
    logic             busy_reg,   busy_next;
    logic             done_reg,   done_next;

    logic fs_d;
    logic fs_br;

    full_subtractor u_fs (
        .d      (fs_d),
        .br_out (fs_br),
        .a      (a_sh_reg[0]),
        .b      (b_sh_reg[0]),
        .br_in  (br_reg)
    );

    always_comb begin
        state_next = state_reg;
        a_sh_next  = a_sh_reg;
        b_sh_next  = b_sh_reg;
        diff_next  = diff_reg;
        cnt_next   = cnt_reg;
        br_next    = br_reg;
        bout_next  = bout_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    a_sh_next  = a;
                    b_sh_next  = b;
                    br_next    = bin;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                end
            end
            RUN: begin
                // Operands shift right so bit 0 always feeds the subtractor cell.
                a_sh_next = a_sh_reg >> 1;
                b_sh_next = b_sh_reg >> 1;
                br_next   = fs_br;
                diff_next = {fs_d, diff_reg[WIDTH-1:1]};
                cnt_next  = cnt_reg + CW'(1);
                if (cnt_reg == LAST_BIT) begin
                    state_next = DONE;
                    busy_next  = 1'b0;
                    bout_next  = fs_br;
                end
            end
            DONE: begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            diff_reg  <= '0;
            cnt_reg   <= '0;
            br_reg    <= 1'b0;
            bout_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_sh_reg  <= a_sh_next;
            b_sh_reg  <= b_sh_next;
            diff_reg  <= diff_next;
            cnt_reg   <= cnt_next;
            br_reg    <= br_next;
            bout_reg  <= bout_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign diff = diff_reg;
    assign bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8: directed vectors plus random back-to-back ops.
module tb_serial_subtractor;

    localparam int W       = 8;
    localparam int LATENCY = W + 1;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        int           start_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse pops one expectation; a done with nothing pending is an error.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("diff", 32'(diff), 32'(e.diff));
                check("bout", 32'(bout), 32'(e.bout));
                check("latency", 32'(cyc - e.start_cyc), 32'(LATENCY));
                $display("op done: diff=%02h bout=%0d latency=%0d", diff, bout, cyc - e.start_cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge where the next start can be issued.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                          input logic [W-1:0] exp_diff, input logic exp_bout);
        exp_t e;
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        bin   = tbin;
        e.diff      = exp_diff;
        e.bout      = exp_bout;
        e.start_cyc = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
        check("busy_run", 32'(busy), 32'd1);
        repeat (LATENCY) @(negedge clk);
    endtask

    initial begin
        logic [W:0] model;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rbin;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        @(negedge clk);

        run_op(8'd5,   8'd3,   1'b0, 8'd2,   1'b0);
        run_op(8'd3,   8'd5,   1'b0, 8'hFE, 1'b1);
        run_op(8'd0,   8'd0,   1'b1, 8'hFF, 1'b1);
        run_op(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0);
        run_op(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);
        check("hold_diff", 32'(diff), 32'h00);

        // Start re-asserted with new operands during RUN and DONE must be ignored.
        begin
            exp_t e;
            start = 1'b1;
            a     = 8'd20;
            b     = 8'd7;
            bin   = 1'b0;
            e.diff      = 8'd13;
            e.bout      = 1'b0;
            e.start_cyc = cyc + 1;
            exp_q.push_back(e);
            @(negedge clk);
            start = 1'b0;
            repeat (2) @(negedge clk);
            start = 1'b1;
            a     = 8'd9;
            b     = 8'd1;
            repeat (6) @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            check("restart_idle", 32'(busy), 32'd0);
            repeat (3) @(negedge clk);
        end

        // Reset during the 4th RUN cycle aborts the op with no done pulse.
        start = 1'b1;
        a     = 8'd50;
        b     = 8'd20;
        bin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_bout", 32'(bout), 32'd0);
        repeat (12) @(negedge clk);
        check("abort_idle", 32'(busy), 32'd0);
        run_op(8'd10, 8'd4, 1'b0, 8'd6, 1'b0);

        // Random back-to-back operations against a wide-subtraction reference.
        for (int i = 0; i < 1000; i++) begin
            ra    = W'($urandom);
            rb    = W'($urandom);
            rbin  = 1'($urandom);
            model = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
            run_op(ra, rb, rbin, model[W-1:0], model[W]);
        end

        repeat (4) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
